// File: rtl/reservation_station_param_if.sv
// Dispatch, CDB and issue bundle for the parametrised reservation station.
// The station connects through the slave modport; the driving side uses master.
interface reservation_station_param_if #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 5,
    parameter int CTRL_W  = 9,
    parameter int NUM_CDB = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                      flush;
    logic [1:0]                in_valid;
    logic                      in_ready;
    logic [2*CTRL_W-1:0]       in_ctrl;
    logic [2*TAG_W-1:0]        in_dest_tag;
    logic [1:0]                in_rs_rdy;
    logic [1:0]                in_rt_rdy;
    logic [2*TAG_W-1:0]        in_rs_tag;
    logic [2*TAG_W-1:0]        in_rt_tag;
    logic [2*DATA_W-1:0]       in_rs_val;
    logic [2*DATA_W-1:0]       in_rt_val;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_data;
    logic [1:0]                iss_valid;
    logic [1:0]                iss_ready;
    logic [2*CTRL_W-1:0]       iss_ctrl;
    logic [2*TAG_W-1:0]        iss_dest_tag;
    logic [2*DATA_W-1:0]       iss_rs_val;
    logic [2*DATA_W-1:0]       iss_rt_val;
    logic [CNT_W-1:0]          free_cnt;
    logic                      full;

    modport master (
        output flush, in_valid, in_ctrl, in_dest_tag,
        output in_rs_rdy, in_rt_rdy, in_rs_tag, in_rt_tag,
        output in_rs_val, in_rt_val,
        output cdb_valid, cdb_tag, cdb_data, iss_ready,
        input  in_ready, iss_valid, iss_ctrl, iss_dest_tag,
        input  iss_rs_val, iss_rt_val, free_cnt, full
    );

    modport slave (
        input  flush, in_valid, in_ctrl, in_dest_tag,
        input  in_rs_rdy, in_rt_rdy, in_rs_tag, in_rt_tag,
        input  in_rs_val, in_rt_val,
        input  cdb_valid, cdb_tag, cdb_data, iss_ready,
        output in_ready, iss_valid, iss_ctrl, iss_dest_tag,
        output iss_rs_val, iss_rt_val, free_cnt, full
    );
endinterface

// File: rtl/reservation_station_param.sv
// Two-wide arithmetic reservation station with CDB wakeup and
// age-matrix oldest-first selection onto two ALU issue ports.
module reservation_station_param #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 5,
    parameter int CTRL_W  = 9,
    parameter int NUM_CDB = 4
) (
    input logic                        clk,
    input logic                        rst,
    reservation_station_param_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [TAG_W-1:0]  dest;
        logic              rs_rdy;
        logic [TAG_W-1:0]  rs_tag;
        logic [DATA_W-1:0] rs_val;
        logic              rt_rdy;
        logic [TAG_W-1:0]  rt_tag;
        logic [DATA_W-1:0] rt_val;
    } entry_t;

    logic [DEPTH-1:0] valid_q, valid_d;
    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    // age_q[i][j] set means entry i is older than entry j
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];

    logic [DEPTH-1:0] rdy, free, rem, iss_clr;
    logic [DEPTH-1:0] sel [2];
    logic [DEPTH-1:0] oh  [2];
    logic [CNT_W-1:0] older [DEPTH];
    logic [CNT_W-1:0] free_cnt;
    logic [1:0]       wr, iss_valid;
    logic             in_ready;
    entry_t           new_ent [2];
    entry_t           pay [2];

    // Lowest-index matching bus wins; MSB of result flags a hit.
    function automatic logic [DATA_W:0] cdb_hit(
        input logic [TAG_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        v,
        input logic [NUM_CDB*TAG_W-1:0]  t,
        input logic [NUM_CDB*DATA_W-1:0] d
    );
        logic [DATA_W:0] h;
        h = '0;
        for (int b = NUM_CDB - 1; b >= 0; b--)
            if (v[b] && t[b*TAG_W +: TAG_W] == tag)
                h = {1'b1, d[b*DATA_W +: DATA_W]};
        return h;
    endfunction

    function automatic entry_t wake(
        input entry_t                    e,
        input logic [NUM_CDB-1:0]        v,
        input logic [NUM_CDB*TAG_W-1:0]  t,
        input logic [NUM_CDB*DATA_W-1:0] d
    );
        entry_t          r;
        logic [DATA_W:0] hs, ht;
        r  = e;
        hs = cdb_hit(e.rs_tag, v, t, d);
        ht = cdb_hit(e.rt_tag, v, t, d);
        if (!e.rs_rdy && hs[DATA_W]) begin
            r.rs_rdy = 1'b1;
            r.rs_val = hs[DATA_W-1:0];
        end
        if (!e.rt_rdy && ht[DATA_W]) begin
            r.rt_rdy = 1'b1;
            r.rt_val = ht[DATA_W-1:0];
        end
        return r;
    endfunction

    // Free count, insert gating and free-entry allocation for both slots
    always_comb begin
        free     = ~valid_q;
        free_cnt = '0;
        for (int i = 0; i < DEPTH; i++)
            if (free[i]) free_cnt = free_cnt + CNT_W'(1);
        in_ready = (free_cnt >= CNT_W'(2));
        wr[0]    = bus.in_valid[0] & in_ready & ~bus.flush;
        wr[1]    = bus.in_valid[1] & in_ready & ~bus.flush;
        oh[0]    = free & (~free + DEPTH'(1));
        rem      = free & ~(bus.in_valid[0] ? oh[0] : '0);
        oh[1]    = rem & (~rem + DEPTH'(1));
    end

    // Build incoming entries, capturing any CDB broadcast in flight
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            new_ent[k].ctrl   = bus.in_ctrl[k*CTRL_W +: CTRL_W];
            new_ent[k].dest   = bus.in_dest_tag[k*TAG_W +: TAG_W];
            new_ent[k].rs_rdy = bus.in_rs_rdy[k];
            new_ent[k].rs_tag = bus.in_rs_tag[k*TAG_W +: TAG_W];
            new_ent[k].rs_val = bus.in_rs_val[k*DATA_W +: DATA_W];
            new_ent[k].rt_rdy = bus.in_rt_rdy[k];
            new_ent[k].rt_tag = bus.in_rt_tag[k*TAG_W +: TAG_W];
            new_ent[k].rt_val = bus.in_rt_val[k*DATA_W +: DATA_W];
            new_ent[k] = wake(new_ent[k], bus.cdb_valid,
                              bus.cdb_tag, bus.cdb_data);
        end
    end

    // Oldest and second-oldest ready entries drive ports 0 and 1
    always_comb begin
        sel[0] = '0;
        sel[1] = '0;
        for (int i = 0; i < DEPTH; i++)
            rdy[i] = valid_q[i] & ent_q[i].rs_rdy & ent_q[i].rt_rdy;
        for (int i = 0; i < DEPTH; i++) begin
            older[i] = '0;
            for (int j = 0; j < DEPTH; j++)
                if (j != i && rdy[j] && age_q[j][i])
                    older[i] = older[i] + CNT_W'(1);
            sel[0][i] = rdy[i] && older[i] == CNT_W'(0);
            sel[1][i] = rdy[i] && older[i] == CNT_W'(1);
        end
        for (int k = 0; k < 2; k++) begin
            pay[k] = '0;
            for (int i = 0; i < DEPTH; i++)
                if (sel[k][i]) pay[k] = ent_q[i];
            iss_valid[k] = (|sel[k]) & ~bus.flush;
        end
        iss_clr = (sel[0] & {DEPTH{iss_valid[0] & bus.iss_ready[0]}})
                | (sel[1] & {DEPTH{iss_valid[1] & bus.iss_ready[1]}});
    end

    // Next state: issue, wakeup, insert (slot 0 then slot 1), flush last
    always_comb begin
        valid_d = valid_q & ~iss_clr;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = wake(ent_q[i], bus.cdb_valid,
                            bus.cdb_tag, bus.cdb_data);
            age_d[i] = age_q[i];
        end
        for (int k = 0; k < 2; k++)
            if (wr[k])
                for (int i = 0; i < DEPTH; i++)
                    if (oh[k][i]) begin
                        valid_d[i] = 1'b1;
                        ent_d[i]   = new_ent[k];
                        age_d[i]   = '0;
                        for (int j = 0; j < DEPTH; j++)
                            if (j != i) age_d[j][i] = 1'b1;
                    end
        if (bus.flush) valid_d = '0;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.free_cnt     = free_cnt;
    assign bus.full         = (free_cnt == '0);
    assign bus.iss_valid    = iss_valid;
    assign bus.iss_ctrl     = {pay[1].ctrl, pay[0].ctrl};
    assign bus.iss_dest_tag = {pay[1].dest, pay[0].dest};
    assign bus.iss_rs_val   = {pay[1].rs_val, pay[0].rs_val};
    assign bus.iss_rt_val   = {pay[1].rt_val, pay[0].rt_val};
endmodule

// File: tb/tb_reservation_station_param.sv
// Directed vector bench for reservation_station_param (default parameters).
// Each vector drives one cycle of inputs and checks the outputs of that cycle.
module tb_reservation_station_param;
    logic clk;
    logic rst;

    reservation_station_param_if #(
        .DEPTH(8), .DATA_W(32), .TAG_W(5), .CTRL_W(9), .NUM_CDB(4)
    ) bus ();

    reservation_station_param #(
        .DEPTH(8), .DATA_W(32), .TAG_W(5), .CTRL_W(9), .NUM_CDB(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  iv;
        logic [8:0]  c0;
        logic [8:0]  c1;
        logic [31:0] rs0;
        logic [3:0]  fc;
        logic        ir;
        logic        fu;
    } exp_t;

    typedef struct {
        string       nm;
        logic [1:0]  iv;
        logic [8:0]  c0;
        logic [8:0]  c1;
        logic [1:0]  rsr;
        logic [4:0]  rtag;
        logic        cv;
        int          cb;
        logic [4:0]  ctag;
        logic [31:0] cdat;
        logic [1:0]  ir;
        logic        fl;
        exp_t        e;
    } vec_t;

    int   n_vec;
    int   n_miss;
    vec_t tbl [$];

    function automatic vec_t mk(
        input string nm, input logic [1:0] iv,
        input logic [8:0] c0, input logic [8:0] c1,
        input logic [1:0] rsr, input logic [4:0] rtag,
        input logic cv, input int cb,
        input logic [4:0] ctag, input logic [31:0] cdat,
        input logic [1:0] ir, input logic fl,
        input logic [1:0] eiv, input logic [8:0] ec0,
        input logic [8:0] ec1, input logic [31:0] ers0,
        input logic [3:0] efc
    );
        vec_t v;
        v.nm = nm; v.iv = iv; v.c0 = c0; v.c1 = c1;
        v.rsr = rsr; v.rtag = rtag; v.cv = cv; v.cb = cb;
        v.ctag = ctag; v.cdat = cdat; v.ir = ir; v.fl = fl;
        v.e.iv = eiv; v.e.c0 = ec0; v.e.c1 = ec1; v.e.rs0 = ers0;
        v.e.fc = efc; v.e.ir = (efc >= 4'd2); v.e.fu = (efc == 4'd0);
        return v;
    endfunction

    task automatic chk(input string nm, input exp_t e);
        logic        bad;
        logic [8:0]  c0, c1;
        logic [31:0] r0;
        c0 = bus.iss_ctrl[8:0];
        c1 = bus.iss_ctrl[17:9];
        r0 = bus.iss_rs_val[31:0];
        bad = (bus.iss_valid !== e.iv) || (bus.free_cnt !== e.fc)
           || (bus.in_ready !== e.ir) || (bus.full !== e.fu);
        if (e.iv[0]) bad = bad || (c0 !== e.c0) || (r0 !== e.rs0);
        if (e.iv[1]) bad = bad || (c1 !== e.c1);
        n_vec++;
        if (bad) begin
            n_miss++;
            $display("FAIL %s: got iv=%b c0=%h c1=%h rs0=%h fc=%0d rdy=%b full=%b / want iv=%b c0=%h c1=%h rs0=%h fc=%0d rdy=%b full=%b",
                     nm, bus.iss_valid, c0, c1, r0, bus.free_cnt,
                     bus.in_ready, bus.full, e.iv, e.c0, e.c1, e.rs0,
                     e.fc, e.ir, e.fu);
        end
    endtask

    task automatic chk_zero(input string nm);
        n_vec++;
        if (bus.iss_valid !== 2'b00 || bus.iss_ctrl !== '0
            || bus.iss_dest_tag !== '0 || bus.iss_rs_val !== '0
            || bus.iss_rt_val !== '0 || bus.free_cnt !== 4'd8
            || bus.in_ready !== 1'b1 || bus.full !== 1'b0) begin
            n_miss++;
            $display("FAIL %s: got iv=%b ctrl=%h rs=%h fc=%0d rdy=%b full=%b / want iv=00 payload=0 fc=8 rdy=1 full=0",
                     nm, bus.iss_valid, bus.iss_ctrl, bus.iss_rs_val,
                     bus.free_cnt, bus.in_ready, bus.full);
        end
    endtask

    task automatic drive(input vec_t v);
        logic [3:0]   cv;
        logic [19:0]  ct;
        logic [127:0] cd;
        cv = '0; ct = '0; cd = '0;
        if (v.cv) begin
            cv[v.cb]          = 1'b1;
            ct[v.cb*5 +: 5]   = v.ctag;
            cd[v.cb*32 +: 32] = v.cdat;
        end
        bus.flush       = v.fl;
        bus.in_valid    = v.iv;
        bus.in_ctrl     = {v.c1, v.c0};
        bus.in_dest_tag = {v.c1[4:0], v.c0[4:0]};
        bus.in_rs_rdy   = v.rsr;
        bus.in_rt_rdy   = 2'b11;
        bus.in_rs_tag   = {v.rtag, v.rtag};
        bus.in_rt_tag   = '0;
        bus.in_rs_val   = {32'h100 + 32'(v.c1), 32'h100 + 32'(v.c0)};
        bus.in_rt_val   = {32'h200 + 32'(v.c1), 32'h200 + 32'(v.c0)};
        bus.cdb_valid   = cv;
        bus.cdb_tag     = ct;
        bus.cdb_data    = cd;
        bus.iss_ready   = v.ir;
    endtask

    task automatic apply(input vec_t v);
        drive(v);
        #1;
        chk(v.nm, v.e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        exp_t e;
        n_vec  = 0;
        n_miss = 0;
        idle   = mk("idle", 2'b00, 9'h0, 9'h0, 2'b00, 5'd0, 1'b0, 0,
                    5'd0, 32'h0, 2'b00, 1'b0, 2'b00, 9'h0, 9'h0, 32'h0, 4'd8);

        // two ready inserts, then issue both
        tbl.push_back(mk("ins2",  2'b11, 9'h01, 9'h02, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b00, 1'b0, 2'b00, 9'h00, 9'h00, 32'h0, 4'd8));
        tbl.push_back(mk("iss2",  2'b00, 9'h00, 9'h00, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b11, 1'b0, 2'b11, 9'h01, 9'h02, 32'h101, 4'd6));
        // A waits on tag 7, B ready; wake A from the last bus
        tbl.push_back(mk("insAB", 2'b11, 9'h0A, 9'h0B, 2'b10, 5'd7, 1'b0, 0, 5'd0, 32'h0, 2'b00, 1'b0, 2'b00, 9'h00, 9'h00, 32'h0, 4'd8));
        tbl.push_back(mk("bcast", 2'b00, 9'h00, 9'h00, 2'b11, 5'd0, 1'b1, 3, 5'd7, 32'hDEAD, 2'b11, 1'b0, 2'b01, 9'h0B, 9'h00, 32'h10B, 4'd6));
        tbl.push_back(mk("wakeA", 2'b00, 9'h00, 9'h00, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b11, 1'b0, 2'b01, 9'h0A, 9'h00, 32'hDEAD, 4'd7));
        // dispatch-time capture from bus 0
        tbl.push_back(mk("dcap",  2'b01, 9'h0C, 9'h00, 2'b00, 5'd3, 1'b1, 0, 5'd3, 32'hBEEF, 2'b00, 1'b0, 2'b00, 9'h00, 9'h00, 32'h0, 4'd8));
        tbl.push_back(mk("dcapi", 2'b00, 9'h00, 9'h00, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b01, 1'b0, 2'b01, 9'h0C, 9'h00, 32'hBEEF, 4'd7));
        // three ready entries drained through port 0 only
        tbl.push_back(mk("ins3a", 2'b11, 9'h21, 9'h22, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b00, 1'b0, 2'b00, 9'h00, 9'h00, 32'h0, 4'd8));
        tbl.push_back(mk("ins3b", 2'b01, 9'h23, 9'h00, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b01, 1'b0, 2'b11, 9'h21, 9'h22, 32'h121, 4'd6));
        tbl.push_back(mk("p0_2",  2'b00, 9'h00, 9'h00, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b01, 1'b0, 2'b11, 9'h22, 9'h23, 32'h122, 4'd6));
        tbl.push_back(mk("p0_3",  2'b00, 9'h00, 9'h00, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b01, 1'b0, 2'b01, 9'h23, 9'h00, 32'h123, 4'd7));
        // reused low entry must still be youngest
        tbl.push_back(mk("age_a", 2'b11, 9'h31, 9'h32, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b00, 1'b0, 2'b00, 9'h00, 9'h00, 32'h0, 4'd8));
        tbl.push_back(mk("age_b", 2'b00, 9'h00, 9'h00, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b01, 1'b0, 2'b11, 9'h31, 9'h32, 32'h131, 4'd6));
        tbl.push_back(mk("age_c", 2'b01, 9'h33, 9'h00, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b00, 1'b0, 2'b01, 9'h32, 9'h00, 32'h132, 4'd7));
        tbl.push_back(mk("age_d", 2'b00, 9'h00, 9'h00, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b11, 1'b0, 2'b11, 9'h32, 9'h33, 32'h132, 4'd6));
        tbl.push_back(mk("empty", 2'b00, 9'h00, 9'h00, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b00, 1'b0, 2'b00, 9'h00, 9'h00, 32'h0, 4'd8));

        rst = 1'b1;
        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // fill with stalled entries, wake all, then partial issue
        apply(mk("fill1", 2'b11, 9'h40, 9'h41, 2'b00, 5'd9, 1'b0, 0, 5'd0, 32'h0, 2'b00, 1'b0, 2'b00, 9'h00, 9'h00, 32'h0, 4'd8));
        apply(mk("fill2", 2'b11, 9'h42, 9'h43, 2'b00, 5'd9, 1'b0, 0, 5'd0, 32'h0, 2'b00, 1'b0, 2'b00, 9'h00, 9'h00, 32'h0, 4'd6));
        apply(mk("fill3", 2'b11, 9'h44, 9'h45, 2'b00, 5'd9, 1'b0, 0, 5'd0, 32'h0, 2'b00, 1'b0, 2'b00, 9'h00, 9'h00, 32'h0, 4'd4));
        apply(mk("fill4", 2'b11, 9'h46, 9'h47, 2'b00, 5'd9, 1'b0, 0, 5'd0, 32'h0, 2'b00, 1'b0, 2'b00, 9'h00, 9'h00, 32'h0, 4'd2));
        apply(mk("full",  2'b11, 9'h50, 9'h51, 2'b11, 5'd0, 1'b1, 1, 5'd9, 32'h5555, 2'b00, 1'b0, 2'b00, 9'h00, 9'h00, 32'h0, 4'd0));
        apply(mk("hold1", 2'b00, 9'h00, 9'h00, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b00, 1'b0, 2'b11, 9'h40, 9'h41, 32'h5555, 4'd0));
        apply(mk("hold2", 2'b00, 9'h00, 9'h00, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b10, 1'b0, 2'b11, 9'h40, 9'h41, 32'h5555, 4'd0));
        apply(mk("p1out", 2'b00, 9'h00, 9'h00, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b00, 1'b0, 2'b11, 9'h40, 9'h42, 32'h5555, 4'd1));
        apply(mk("bothx", 2'b00, 9'h00, 9'h00, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b11, 1'b0, 2'b11, 9'h40, 9'h42, 32'h5555, 4'd1));
        // flush with five residents plus a colliding insert
        apply(mk("flush", 2'b11, 9'h60, 9'h61, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b11, 1'b1, 2'b00, 9'h00, 9'h00, 32'h0, 4'd3));
        apply(mk("postf", 2'b00, 9'h00, 9'h00, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b00, 1'b0, 2'b00, 9'h00, 9'h00, 32'h0, 4'd8));

        // asynchronous reset between clock edges
        apply(mk("pre_r", 2'b11, 9'h70, 9'h71, 2'b11, 5'd0, 1'b0, 0, 5'd0, 32'h0, 2'b00, 1'b0, 2'b00, 9'h00, 9'h00, 32'h0, 4'd8));
        drive(idle);
        #1;
        e = '{iv: 2'b11, c0: 9'h70, c1: 9'h71, rs0: 32'h170, fc: 4'd6, ir: 1'b1, fu: 1'b0};
        chk("pre_r2", e);
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("post_r");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
